// File: rtl/wave_pkg.sv
// Shared constants, FSM state type and quotient saturation for the wave rate controller.
package wave_pkg;

    localparam int CLK_HZ_DEFAULT     = 50_000_000;
    localparam int PHASE_BITS_DEFAULT = 12;
    localparam int FREQ_W             = 8;
    localparam int DIVIDEND_W         = 26;
    localparam int DIVISOR_W          = 20;
    localparam int PERIOD_W           = 16;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        ARM
    } rate_state_e;

    function automatic logic [PERIOD_W-1:0] saturate_period(input logic [DIVIDEND_W-1:0] q);
        return (|q[DIVIDEND_W-1:PERIOD_W]) ? {PERIOD_W{1'b1}} : q[PERIOD_W-1:0];
    endfunction

endpackage

// File: rtl/seq_div.sv
// Start/done restoring divider producing one quotient bit per cycle (DIVIDEND_W cycles).
module seq_div #(
    parameter int DIVIDEND_W = 26,
    parameter int DIVISOR_W  = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    logic [DIVIDEND_W-1:0] quo_q;
    logic [DIVISOR_W-1:0]  rem_q;
    logic [DIVISOR_W-1:0]  dsr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  run_q;
    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W-1:0]  diff;
    logic                  fits;

    // The remainder stays below the divisor, so the difference always fits in DIVISOR_W bits.
    always_comb begin
        trial = {rem_q, quo_q[DIVIDEND_W-1]};
        fits  = trial >= {1'b0, dsr_q};
        diff  = trial[DIVISOR_W-1:0] - dsr_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quo_q <= dividend;
                rem_q <= '0;
                dsr_q <= divisor;
                cnt_q <= CNT_W'(DIVIDEND_W);
                run_q <= 1'b1;
            end else if (run_q) begin
                quo_q <= {quo_q[DIVIDEND_W-2:0], fits};
                rem_q <= fits ? diff : trial[DIVISOR_W-1:0];
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    run_q <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/wave_rate_ctrl.sv
// Sample-rate controller: frequency request -> divider period, sample strobe and table phase.
// Define WAVE_RATE_ROUND_EN to round the period to nearest instead of flooring it.
module wave_rate_ctrl
    import wave_pkg::*;
#(
    parameter int CLK_HZ     = CLK_HZ_DEFAULT,
    parameter int PHASE_BITS = PHASE_BITS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [FREQ_W-1:0]     cfg_freq,
    input  logic                  run_en,
    output logic                  sample_stb,
    output logic [PHASE_BITS-1:0] phase,
    output logic                  wrap,
    output logic                  busy,
    output logic [PERIOD_W-1:0]   period
);

    rate_state_e           state_q, state_d;
    logic                  accept, div_start, div_done, apply;
    logic [DIVIDEND_W-1:0] dividend, quotient;
    logic [DIVISOR_W-1:0]  divisor;
    logic [PERIOD_W-1:0]   pending_q, period_q, cnt_q;
    logic [PHASE_BITS-1:0] phase_q;

    assign busy       = (state_q != IDLE);
    assign cfg_ready  = !busy;
    assign accept     = cfg_valid && cfg_ready;
    assign sample_stb = run_en && (period_q != '0) && (cnt_q == period_q - PERIOD_W'(1));
    assign wrap       = sample_stb && (&phase_q);
    // New rates land only on a table boundary, or immediately when nothing is being played.
    assign apply      = (state_q == ARM) && (wrap || !run_en || (period_q == '0));

    assign divisor = DIVISOR_W'(cfg_freq) << PHASE_BITS;
`ifdef WAVE_RATE_ROUND_EN
    assign dividend = DIVIDEND_W'(CLK_HZ) + (DIVIDEND_W'(cfg_freq) << (PHASE_BITS - 1));
`else
    assign dividend = DIVIDEND_W'(CLK_HZ);
`endif

    seq_div #(
        .DIVIDEND_W(DIVIDEND_W),
        .DIVISOR_W (DIVISOR_W)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (div_start),
        .dividend(dividend),
        .divisor (divisor),
        .done    (div_done),
        .quotient(quotient)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                state_d   = (cfg_freq == '0) ? ARM : DIV;
                div_start = (cfg_freq != '0);
            end
            DIV:     if (div_done) state_d = ARM;
            ARM:     if (apply)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else if (accept && (cfg_freq == '0)) begin
            pending_q <= '0;
        end else if ((state_q == DIV) && div_done) begin
            pending_q <= saturate_period(quotient);
        end
    end

    // A wrap-triggered load also takes the strobe, so phase lands on 0 with the new rate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '0;
            cnt_q    <= '0;
            phase_q  <= '0;
        end else if (apply) begin
            period_q <= pending_q;
            cnt_q    <= '0;
            if (pending_q == '0)  phase_q <= '0;
            else if (sample_stb)  phase_q <= phase_q + PHASE_BITS'(1);
        end else if (sample_stb) begin
            cnt_q   <= '0;
            phase_q <= phase_q + PHASE_BITS'(1);
        end else if (run_en && (period_q != '0)) begin
            cnt_q <= cnt_q + PERIOD_W'(1);
        end
    end

    assign period = period_q;
    assign phase  = phase_q;

endmodule

// File: tb/tb_wave_rate_ctrl.sv
// Self-checking bench for wave_rate_ctrl. A 16-entry table with CLK_HZ=195312 yields the same
// divider periods as 50 MHz / 4096 (122, 47, 12207; 48 when rounding), so wraps are reachable.
module tb_wave_rate_ctrl;

    localparam int CLK_HZ  = 195_312;
    localparam int PB      = 4;
    localparam int PMAX    = (1 << PB) - 1;
    localparam int EXP_100 = 122;
    localparam int EXP_1   = 12207;
`ifdef WAVE_RATE_ROUND_EN
    localparam int EXP_255 = 48;
`else
    localparam int EXP_255 = 47;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cfg_valid = 1'b0;
    logic [7:0]    cfg_freq = 8'd0;
    logic          run_en = 1'b0;
    logic          cfg_ready, sample_stb, wrap, busy;
    logic [PB-1:0] phase;
    logic [15:0]   period;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wave_rate_ctrl #(.CLK_HZ(CLK_HZ), .PHASE_BITS(PB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_freq  (cfg_freq),
        .run_en    (run_en),
        .sample_stb(sample_stb),
        .phase     (phase),
        .wrap      (wrap),
        .busy      (busy),
        .period    (period)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int exp_period(input int f);
        int q;
        if (f == 0) return 0;
`ifdef WAVE_RATE_ROUND_EN
        q = (CLK_HZ + f * (1 << (PB - 1))) / (f * (1 << PB));
`else
        q = CLK_HZ / (f * (1 << PB));
`endif
        return (q > 65535) ? 65535 : q;
    endfunction

    int m_period = 0, m_left = 0, m_phase = 0, m_pending = 0, m_div_left = 0;
    bit m_busy = 1'b0;
    bit mx_stb, mx_wrap, mx_apply, mx_acc;

    // m_left: cycles still to run (including this one) until the next strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_period = 0; m_left = 0; m_phase = 0; m_pending = 0; m_div_left = 0; m_busy = 1'b0;
        end else begin
            mx_stb   = run_en && m_period != 0 && m_left == 1;
            mx_wrap  = mx_stb && m_phase == PMAX;
            mx_apply = m_busy && m_div_left == 0 && (mx_wrap || !run_en || m_period == 0);
            mx_acc   = cfg_valid && !m_busy;
            if (mx_stb) begin
                m_left  = m_period;
                m_phase = (m_phase + 1) % (PMAX + 1);
            end else if (run_en && m_period != 0) begin
                m_left--;
            end
            if (mx_apply) begin
                m_period = m_pending;
                m_left   = m_pending;
                if (m_pending == 0) m_phase = 0;
                m_busy = 1'b0;
            end else if (m_busy && m_div_left > 0) begin
                m_div_left--;
            end
            if (mx_acc) begin
                m_pending  = exp_period(int'(cfg_freq));
                m_busy     = 1'b1;
                m_div_left = (cfg_freq == 0) ? 0 : 27;
            end
        end
    end

    logic [31:0] dut_vec, mdl_vec;
    always @(negedge clk) begin
        dut_vec = {8'h0, cfg_ready, busy, sample_stb, wrap, phase, period};
        mdl_vec = {8'h0, !m_busy, m_busy,
                   (run_en && m_period != 0 && m_left == 1),
                   (run_en && m_period != 0 && m_left == 1 && m_phase == PMAX),
                   PB'(m_phase), 16'(m_period)};
        check("cycle {rdy,busy,stb,wrap,phase,period}", dut_vec, mdl_vec);
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_for(input int what, input int max_cyc, output int t, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge clk);
            case (what)
                0:       ok = sample_stb;
                1:       ok = wrap;
                2:       ok = !busy;
                default: ok = cfg_ready;
            endcase
        end
        t = cyc;
    endtask

    task automatic send(input logic [7:0] f, output int t_acc);
        bit ok;
        int t;
        if (!cfg_ready) begin
            wait_for(3, 3000, t, ok);
            check("ready_timeout", ok, 1);
        end
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        cfg_freq  = f;
        @(posedge clk); #1;
        t_acc     = cyc;
        cfg_valid = 1'b0;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  t, t2, t_acc, t_load, t_s, t_w, nstb;
        bit  ok;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_cfg_ready", cfg_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_period", period, 0);
        check("reset_phase", phase, 0);
        check("reset_stb_wrap", {sample_stb, wrap}, 0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        run_en = 1'b1;

        // Request 100 Hz from the stopped state.
        send(8'd100, t_acc);
        wait_for(2, 100, t_load, ok);
        check("busy_fall_timeout", ok, 1);
        check("accept_to_idle_cycles", t_load - t_acc, 28);
        check("period_100", period, EXP_100);
        wait_for(0, 300, t, ok);
        check("first_stb_after_load", t - t_load, EXP_100 - 1);
        wait_for(0, 300, t2, ok);
        check("stb_spacing_100", t2 - t, EXP_100);
        wait_for(1, 2500, t_w, ok);
        check("wrap_timeout", ok, 1);
        check("wrap_after_16_strobes", t_w - t_load, 16 * EXP_100 - 1);
        check("wrap_phase", phase, PMAX);

        // Running at 100, request 255: takes effect only at the next wrap.
        send(8'd255, t_acc);
        repeat (30) @(negedge clk);
        check("period_held_until_wrap", period, EXP_100);
        check("busy_while_pending", busy, 1);
        wait_for(1, 2500, t, ok);
        check("wrap2_timeout", ok, 1);
        check("wrap2_spacing", t - t_w, 16 * EXP_100);
        @(negedge clk);
        check("period_255_applied", period, EXP_255);
        check("phase_zero_after_apply", phase, 0);
        check("busy_clear_after_apply", busy, 0);
        wait_for(0, 300, t2, ok);
        check("first_stb_at_255", t2 - t, EXP_255);

        // Stop request: outputs stop at the next wrap.
        send(8'd0, t_acc);
        wait_for(1, 1000, t, ok);
        check("stop_wrap_timeout", ok, 1);
        @(negedge clk);
        check("stopped_period", period, 0);
        check("stopped_phase", phase, 0);
        nstb = 0;
        repeat (200) begin
            @(negedge clk);
            if (sample_stb || wrap) nstb++;
        end
        check("no_strobes_when_stopped", nstb, 0);

        // Restart at 100, pause mid-table at phase 10 and resume.
        send(8'd100, t_acc);
        wait_for(2, 100, t_load, ok);
        check("restart_latency", t_load - t_acc, 28);
        t_s = 0;
        for (int i = 0; i < 10; i++) wait_for(0, 300, t_s, ok);
        repeat (40) @(posedge clk);
        #1 run_en = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("phase_held_while_paused", phase, 10);
        run_en = 1'b1;
        wait_for(0, 300, t, ok);
        check("resume_remaining_count", t - t_s, EXP_100 + 300);

        // run_en dropping during ARM applies the pending period next cycle.
        send(8'd255, t_acc);
        repeat (27) @(posedge clk);
        #1 run_en = 1'b0;
        @(negedge clk);
        check("arm_period_unchanged", period, EXP_100);
        check("arm_busy", busy, 1);
        @(negedge clk);
        check("run_en_low_apply", period, EXP_255);
        check("run_en_low_busy_clear", busy, 0);
        @(posedge clk); #1 run_en = 1'b1;

        // Reset at cycle 10 of a divide discards the request.
        send(8'd100, t_acc);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_ready", cfg_ready, 1);
        check("midreset_busy", busy, 0);
        check("midreset_period", period, 0);
        check("midreset_phase", phase, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(8'd1, t_acc);
        wait_for(2, 100, t, ok);
        check("latency_1hz", t - t_acc, 28);
        check("period_1hz", period, EXP_1);
        wait_for(0, 13000, t2, ok);
        check("first_stb_1hz", t2 - t, EXP_1 - 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
